// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, ctrl redirect, and the decode handshake.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_target,
        output dec_valid, dec_instr, dec_pc, op, funct3, funct7,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_target,
        input  dec_valid, dec_instr, dec_pc, op, funct3, funct7,
        output dec_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited imem requests, response FIFO toward decode, redirect squash.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises misalign_trap.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          misalign_trap
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  pc;
    logic [31:0]      fifo_instr [DEPTH];
    logic [XLEN-1:0]  fifo_pc    [DEPTH];
    logic [XLEN-1:0]  pcq        [DEPTH];
    logic [PTR_W-1:0] fifo_rd;
    logic [PTR_W-1:0] fifo_wr;
    logic [PTR_W-1:0] pcq_rd;
    logic [PTR_W-1:0] pcq_wr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;

    logic             target_misaligned;
    logic [XLEN-1:0]  target_aligned;
    logic             has_credit;
    logic             req_fire;
    logic             rsp_keep;
    logic             dec_fire;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = |bus.redirect_target[1:0];
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^bus.redirect_target[1:0];
    assign target_misaligned = 1'b0;
`endif

    assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};

    // Buffered plus in-flight words never exceed the FIFO size, so a push always fits.
    assign has_credit = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);

    assign bus.imem_req_valid = (state == FETCH) && has_credit && !bus.redirect;
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep           = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect;

    assign bus.dec_valid = (fifo_count != '0);
    assign dec_fire      = bus.dec_valid && bus.dec_ready;
    assign bus.dec_instr = fifo_instr[fifo_rd];
    assign bus.dec_pc    = fifo_pc[fifo_rd];
    assign bus.op        = fifo_instr[fifo_rd][6:0];
    assign bus.funct3    = fifo_instr[fifo_rd][14:12];
    assign bus.funct7    = fifo_instr[fifo_rd][30];

    // Control state: FSM, PC, credit counters and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_count  <= '0;
        end else begin
            if (bus.redirect) begin
                state <= target_misaligned ? HALT : FETCH;
            end else if (state == IDLE) begin
                state <= FETCH;
            end

            if (bus.redirect) begin
                pc <= target_aligned;
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end

            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (req_fire) begin
                pcq_wr <= pcq_wr + PTR_W'(1);
            end
            if (bus.imem_rsp_valid) begin
                pcq_rd <= pcq_rd + PTR_W'(1);
            end

            // Everything still in flight after this cycle belongs to the squashed path.
            if (bus.redirect) begin
                drop_cnt <= outstanding - CNT_W'(bus.imem_rsp_valid);
            end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end

            if (bus.redirect) begin
                fifo_rd    <= fifo_wr;
                fifo_count <= '0;
            end else begin
                if (rsp_keep) begin
                    fifo_wr <= fifo_wr + PTR_W'(1);
                end
                if (dec_fire) begin
                    fifo_rd <= fifo_rd + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(dec_fire);
            end
        end
    end

    // Storage: request-PC queue and instruction FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
                pcq[i]        <= '0;
            end
        end else begin
            if (req_fire) begin
                pcq[pcq_wr] <= pc;
            end
            if (rsp_keep) begin
                fifo_instr[fifo_wr] <= bus.imem_rsp_data;
                fifo_pc[fifo_wr]    <= pcq[pcq_rd];
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap <= 1'b0;
        end else if (bus.redirect) begin
            misalign_trap <= target_misaligned;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && (fifo_count == CNT_W'(DEPTH))));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-level model of fetch/buffer/squash behaviour.
module tb_fetch_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(XLEN)) bus ();
    fetch_stage_if #(.XLEN(XLEN)) wbus ();

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_trap;
    logic wrap_trap;
`endif

    fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap)
`endif
    );

    // Second instance: wrap-around start PC, memory never answers.
    fetch_stage #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap (wrap_trap)
`endif
    );

    assign wbus.imem_req_ready  = 1'b1;
    assign wbus.imem_rsp_valid  = 1'b0;
    assign wbus.imem_rsp_data   = 32'h0;
    assign wbus.redirect        = 1'b0;
    assign wbus.redirect_target = 32'h0;
    assign wbus.dec_ready       = 1'b0;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } dent_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        bit              stale;
    } rent_t;

    dent_t           m_fifo[$];
    rent_t           m_infl[$];
    logic [XLEN-1:0] m_pc;
    bit              m_started;
    bit              m_halted;
    logic [XLEN-1:0] mem_q[$];

    int n_vec;
    int n_err;
    int fires;

    bit              k_ready;
    bit              k_dec_ready;
    bit              k_rsp_en;
    bit              k_redirect;
    logic [XLEN-1:0] k_target;

    logic            s_rv;
    logic [XLEN-1:0] s_addr;
    logic            s_dv;
    logic [31:0]     s_instr;
    logic [XLEN-1:0] s_pc;
    logic [6:0]      s_op;
    logic [2:0]      s_f3;
    logic            s_f7;
    logic            s_wrv;
    logic [XLEN-1:0] s_waddr;

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h4020_8033;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic knobs(input bit rdy, input bit drdy, input bit rsp);
        k_ready     = rdy;
        k_dec_ready = drdy;
        k_rsp_en    = rsp;
        k_redirect  = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, sample and check at negedge, advance model.
    task automatic cycle();
        bit          exp_rv;
        bit          exp_dv;
        bit          rsp;
        logic [31:0] rdata;
        dent_t       h;
        dent_t       d;
        rent_t       r;

        bus.imem_req_ready  = k_ready;
        bus.dec_ready       = k_dec_ready;
        bus.redirect        = k_redirect;
        bus.redirect_target = k_target;
        rsp = k_rsp_en && (mem_q.size() > 0);
        if (rsp) rdata = mem_word(mem_q[0]);
        else     rdata = $urandom;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rdata;

        @(negedge clk);
        s_rv    = bus.imem_req_valid;
        s_addr  = bus.imem_req_addr;
        s_dv    = bus.dec_valid;
        s_instr = bus.dec_instr;
        s_pc    = bus.dec_pc;
        s_op    = bus.op;
        s_f3    = bus.funct3;
        s_f7    = bus.funct7;
        s_wrv   = wbus.imem_req_valid;
        s_waddr = wbus.imem_req_addr;

        exp_rv = m_started && !m_halted && ((m_fifo.size() + m_infl.size()) < DEPTH) && !k_redirect;
        exp_dv = m_fifo.size() > 0;
        chk("req_valid", 64'(s_rv), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(s_addr), 64'(m_pc));
        chk("dec_valid", 64'(s_dv), 64'(exp_dv));
        if (exp_dv) begin
            h = m_fifo[0];
            chk("dec_instr", 64'(s_instr), 64'(h.instr));
            chk("dec_pc", 64'(s_pc), 64'(h.pc));
            chk("op", 64'(s_op), 64'(h.instr[6:0]));
            chk("funct3", 64'(s_f3), 64'(h.instr[14:12]));
            chk("funct7", 64'(s_f7), 64'(h.instr[30]));
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_trap", 64'(misalign_trap), 64'(m_halted));
`endif

        if (s_rv && k_ready) fires++;
        if (rsp) void'(mem_q.pop_front());
        if (s_rv && k_ready) mem_q.push_back(s_addr);

        if (exp_dv && k_dec_ready) void'(m_fifo.pop_front());
        if (rsp && (m_infl.size() > 0)) begin
            r = m_infl.pop_front();
            if (!r.stale && !k_redirect) begin
                d.instr = rdata;
                d.pc    = r.pc;
                m_fifo.push_back(d);
            end
        end
        if (k_redirect) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = {k_target[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halted = (k_target[1:0] != 2'b00);
`endif
        end else if (exp_rv && k_ready) begin
            r.pc    = m_pc;
            r.stale = 1'b0;
            m_infl.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        m_started = 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        knobs(1'b0, 1'b0, 1'b0);
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.dec_ready       = 1'b0;
        mem_q.delete();
        m_fifo.delete();
        m_infl.delete();
        m_pc      = 32'h0;
        m_started = 1'b0;
        m_halted  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        chk("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
        chk("rst_dec_pc", 64'(bus.dec_pc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        fires    = 0;
        k_target = 32'h0;

        // Streaming with 1-cycle memory and an always-ready decoder.
        do_reset();
        knobs(1'b1, 1'b1, 1'b1);
        cycle();
        chk("first_cycle_no_req", 64'(s_rv), 64'd0);
        chk("wrap_first_cycle_no_req", 64'(s_wrv), 64'd0);
        cycle();
        chk("stream_req0", 64'(s_addr), 64'h0);
        chk("wrap_req0", 64'(s_waddr), 64'hFFFF_FFFC);
        cycle();
        chk("stream_req1", 64'(s_addr), 64'h4);
        chk("wrap_req1", 64'(s_waddr), 64'h0);
        cycle();
        chk("addi_dv", 64'(s_dv), 64'd1);
        chk("addi_pc", 64'(s_pc), 64'h0);
        chk("addi_op", 64'(s_op), 64'b0010011);
        chk("addi_f3", 64'(s_f3), 64'd0);
        chk("addi_f7", 64'(s_f7), 64'd0);
        chk("wrap_req2", 64'(s_waddr), 64'h4);
        cycle();
        chk("stream_req2", 64'(s_addr), 64'h8);
        chk("sub_pc", 64'(s_pc), 64'h4);
        chk("sub_op", 64'(s_op), 64'b0110011);
        chk("sub_f7", 64'(s_f7), 64'd1);
        chk("wrap_req3", 64'(s_waddr), 64'h8);
        cycle();
        chk("wrap_credit_stop", 64'(s_wrv), 64'd0);

        // Backpressure: decoder stalls until two words are buffered.
        do_reset();
        knobs(1'b1, 1'b0, 1'b1);
        repeat (5) cycle();
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("bp_no_req", 64'(s_rv), 64'd0);
            chk("bp_dv", 64'(s_dv), 64'd1);
            chk("bp_hold_pc", 64'(s_pc), 64'h0);
            chk("bp_hold_instr", 64'(s_instr), 64'h0050_0093);
        end
        fires = 0;
        k_dec_ready = 1'b1;
        cycle();
        k_dec_ready = 1'b0;
        cycle();
        chk("bp_release_addr", 64'(s_addr), 64'h8);
        repeat (3) cycle();
        chk("bp_one_request", 64'(fires), 64'd1);

        // Redirect with two requests outstanding; one response lands in the redirect cycle.
        do_reset();
        knobs(1'b1, 1'b1, 1'b0);
        repeat (3) cycle();
        k_rsp_en   = 1'b1;
        k_redirect = 1'b1;
        k_target   = 32'h104;
        cycle();
        chk("redir_cycle_no_req", 64'(s_rv), 64'd0);
        k_redirect = 1'b0;
        cycle();
        chk("redir_req_addr", 64'(s_addr), 64'h104);
        chk("redir_drop0", 64'(s_dv), 64'd0);
        cycle();
        chk("redir_drop1", 64'(s_dv), 64'd0);
        chk("redir_next_addr", 64'(s_addr), 64'h108);
        cycle();
        chk("redir_dec_pc", 64'(s_pc), 64'h104);
        chk("redir_dec_instr", 64'(s_instr), 64'(mem_word(32'h104)));

`ifdef FETCH_MISALIGN_TRAP_EN
        k_redirect = 1'b1;
        k_target   = 32'h102;
        cycle();
        k_redirect = 1'b0;
        fires = 0;
        repeat (3) cycle();
        chk("trap_set", 64'(misalign_trap), 64'd1);
        chk("halt_no_req", 64'(fires), 64'd0);
        k_redirect = 1'b1;
        k_target   = 32'h200;
        cycle();
        k_redirect = 1'b0;
        cycle();
        chk("trap_clear", 64'(misalign_trap), 64'd0);
        chk("resume_addr", 64'(s_addr), 64'h200);
`else
        k_redirect = 1'b1;
        k_target   = 32'h206;
        cycle();
        k_redirect = 1'b0;
        cycle();
        chk("masked_target_addr", 64'(s_addr), 64'h204);
`endif

        // Randomized traffic, with one reset in the middle of activity.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            k_ready     = ($urandom_range(0, 3) != 0);
            k_dec_ready = ($urandom_range(0, 9) < 7);
            k_rsp_en    = ($urandom_range(0, 4) < 3);
            k_redirect  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) k_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            else                           k_target = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 3) == 0) k_target[1:0] = 2'($urandom_range(1, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
